// File: rtl/poly_voice_core.sv
// Polyphonic MIDI voice engine: running-status parser, note-to-voice allocator
// with optional oldest-voice stealing, per-voice square oscillators and a PDM mix.
module poly_voice_core #(
  parameter int unsigned      VOICES   = 4,
  parameter int unsigned      HP_W     = 22,
  parameter bit               STEAL    = 1'b1,
  parameter logic [12*16-1:0] BASE_DIV = {16'd1582, 16'd1676, 16'd1776, 16'd1881,
                                          16'd1993, 16'd2112, 16'd2237, 16'd2370,
                                          16'd2511, 16'd2660, 16'd2819, 16'd2986}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rxByte_i,
  input  logic              rxValid_i,
  input  logic [3:0]        chan_i,
  input  logic              omni_i,
  output logic [VOICES-1:0] oscOut_o,
  output logic [VOICES-1:0] active_o,
  output logic              mixPwm_o
);
  localparam int unsigned AW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned CW = $clog2(VOICES + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(VOICES - 1);

  typedef enum logic [1:0] {NOSTAT, WAIT_D1, WAIT_D2} pstate_e;

  pstate_e    state_q;
  logic [3:0] status_hi_q;
  logic       foreign_q;
  logic [6:0] d1_q;

  logic two_byte, exec, note_on, note_off, all_off;
  logic [6:0] vel;

  assign vel      = rxByte_i[6:0];
  assign two_byte = !(status_hi_q == 4'hC || status_hi_q == 4'hD);
  assign exec     = rxValid_i && !rxByte_i[7] && state_q == WAIT_D2 && !foreign_q;
  assign note_on  = exec && status_hi_q == 4'h9 && vel != 7'd0;
  assign note_off = exec && (status_hi_q == 4'h8 || (status_hi_q == 4'h9 && vel == 7'd0));
  assign all_off  = exec && status_hi_q == 4'hB && d1_q == 7'd123;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= NOSTAT;
      status_hi_q <= 4'h0;
      foreign_q   <= 1'b0;
      d1_q        <= '0;
    end else if (rxValid_i) begin
      if (rxByte_i[7]) begin
        if (rxByte_i[7:4] != 4'hF) begin
          // A status for another channel still owns running status; its data is swallowed.
          status_hi_q <= rxByte_i[7:4];
          foreign_q   <= !(omni_i || rxByte_i[3:0] == chan_i);
          state_q     <= WAIT_D1;
        end else if (!rxByte_i[3]) begin
          state_q   <= NOSTAT;
          foreign_q <= 1'b0;
        end
      end else begin
        case (state_q)
          WAIT_D1: if (two_byte) begin
            d1_q    <= rxByte_i[6:0];
            state_q <= WAIT_D2;
          end
          WAIT_D2: state_q <= WAIT_D1;
          default: ;
        endcase
      end
    end
  end

  // Half-period for the note latched as the first data byte.
  logic [3:0]      oct, semi;
  logic [15:0]     base;
  logic [HP_W-1:0] new_hp;

  assign oct    = 4'(d1_q / 7'd12);
  assign semi   = 4'(d1_q % 7'd12);
  assign base   = BASE_DIV[{semi, 4'b0000} +: 16];
  assign new_hp = HP_W'({16'd0, base} << (4'd10 - oct));

  logic [VOICES-1:0] active_q, active_d, osc_q, osc_d, hit;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [HP_W-1:0]   hp_q   [VOICES];
  logic [HP_W-1:0]   hp_d   [VOICES];
  logic [HP_W-1:0]   cnt_q  [VOICES];
  logic [HP_W-1:0]   cnt_d  [VOICES];
  logic [AW-1:0]     age_q  [VOICES];
  logic [AW-1:0]     age_d  [VOICES];
  logic              hit_any, free_any, alloc;
  logic [AW-1:0]     hit_idx, free_idx, old_idx, tgt;

  always_comb begin
    hit      = '0;
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int i = int'(VOICES) - 1; i >= 0; i--) begin
      hit[i] = active_q[i] && note_q[i] == d1_q;
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = AW'(i);
      end
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = AW'(i);
      end
    end
    for (int i = 1; i < int'(VOICES); i++)
      if (age_q[i] > age_q[old_idx]) old_idx = AW'(i);
  end

  assign alloc = note_on && (hit_any || free_any || STEAL);
  assign tgt   = hit_any ? hit_idx : (free_any ? free_idx : old_idx);

  // NOTE: every _d starts as a copy of its _q, so no path leaves it unassigned (no latch).
  always_comb begin
    active_d = active_q;
    osc_d    = osc_q;
    note_d   = note_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    age_d    = age_q;
    for (int i = 0; i < int'(VOICES); i++) begin
      if (active_q[i]) begin
        if (cnt_q[i] == hp_q[i] - 1'b1) begin
          cnt_d[i] = '0;
          osc_d[i] = ~osc_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (alloc) begin
        if (AW'(i) == tgt) begin
          active_d[i] = 1'b1;
          note_d[i]   = d1_q;
          hp_d[i]     = new_hp;
          age_d[i]    = '0;
          cnt_d[i]    = '0;
          osc_d[i]    = 1'b0;
        end else if (active_q[i] && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
      if (all_off || (note_off && hit[i])) begin
        active_d[i] = 1'b0;
        age_d[i]    = '0;
        cnt_d[i]    = '0;
        osc_d[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
      osc_q    <= '0;
      for (int i = 0; i < int'(VOICES); i++) begin
        note_q[i] <= '0;
        hp_q[i]   <= '0;
        cnt_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      active_q <= active_d;
      osc_q    <= osc_d;
      note_q   <= note_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
    end
  end

  logic [CW-1:0] high_cnt, p_q;
  logic          mix_q;

  always_comb begin
    high_cnt = '0;
    for (int i = 0; i < int'(VOICES); i++) high_cnt = high_cnt + CW'(osc_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      mix_q <= 1'b0;
    end else begin
      mix_q <= p_q < high_cnt;
      p_q   <= (p_q == CW'(VOICES - 1)) ? '0 : p_q + 1'b1;
    end
  end

  assign oscOut_o = osc_q;
  assign active_o = active_q;
  assign mixPwm_o = mix_q;
endmodule

// File: tb/tb_poly_voice_core.sv
// Scoreboard bench for poly_voice_core: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them against a stealing and a non-stealing instance.
module tb_poly_voice_core;
  localparam int V    = 4;
  localparam int H127 = 1993;

  typedef enum int {K_ACT, K_ACT_NS, K_OSC, K_OSC0, K_MIX, K_MIXWIN, K_OSCCNT} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic [3:0]   chan = 4'd0;
  logic         omni = 1'b1;
  logic [V-1:0] osc, act, osc_ns, act_ns;
  logic         mix, mix_ns;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic [3:0] mix_hist = 4'h0;

  poly_voice_core #(.VOICES(V), .STEAL(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .rxByte_i(rx_byte), .rxValid_i(rx_valid),
    .chan_i(chan), .omni_i(omni), .oscOut_o(osc), .active_o(act), .mixPwm_o(mix)
  );

  poly_voice_core #(.VOICES(V), .STEAL(1'b0)) dut_ns (
    .clk_i(clk), .rst_i(rst), .rxByte_i(rx_byte), .rxValid_i(rx_valid),
    .chan_i(chan), .omni_i(omni), .oscOut_o(osc_ns), .active_o(act_ns), .mixPwm_o(mix_ns)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_ACT:    return 32'(act);
      K_ACT_NS: return 32'(act_ns);
      K_OSC:    return 32'(osc);
      K_OSC0:   return 32'(osc[0]);
      K_MIXWIN: return 32'($countones(mix_hist));
      K_OSCCNT: return 32'($countones(osc));
      default:  return 32'(mix);
    endcase
  endfunction

  always @(negedge clk) begin
    mix_hist = {mix_hist[2:0], mix};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due <= cyc) begin
        check(sb_q[i].name, observe(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_at(int due, kind_e k, logic [31:0] e, string name);
    exp_t x;
    x.due  = due;
    x.kind = k;
    x.exp  = e;
    x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic expect_now(kind_e k, logic [31:0] e, string name);
    expect_at(cyc, k, e, name);
  endtask

  task automatic drain(int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations pending after %0d cycles", sb_q.size(), bound);
      sb_q.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, det, n;

    // Reset state.
    tick(3);
    expect_now(K_ACT, 0, "reset_active");
    expect_now(K_ACT_NS, 0, "reset_active_ns");
    expect_now(K_OSC, 0, "reset_osc");
    expect_now(K_MIX, 0, "reset_mix");
    rst = 1'b0;
    tick(2);

    // Basic note-on, running status, velocity-0 release, 0x8n release.
    send(8'h90); send(8'h3C); send(8'h64);
    expect_now(K_ACT, 4'b0001, "noteon_60_v0");
    send(8'h40); send(8'h64);
    expect_now(K_ACT, 4'b0011, "running_status_v1");
    send(8'h3C); send(8'h00);
    expect_now(K_ACT, 4'b0010, "vel0_release_v0");
    send(8'h80); send(8'h40); send(8'h00);
    expect_now(K_ACT, 4'b0000, "noteoff_8n");
    expect_now(K_ACT_NS, 4'b0000, "noteoff_8n_ns");

    // Five note-ons into four voices: oldest (voice0) stolen vs dropped.
    send(8'h90);
    send(8'h3C); send(8'h64);
    send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64);
    send(8'h41); send(8'h64);
    expect_now(K_ACT, 4'b1111, "four_voices");
    send(8'h43); send(8'h64);
    expect_now(K_ACT, 4'b1111, "steal_full");
    expect_now(K_ACT_NS, 4'b1111, "nosteal_full");
    send(8'h43); send(8'h00);
    expect_now(K_ACT, 4'b1110, "steal_67_in_v0");
    expect_now(K_ACT_NS, 4'b1111, "nosteal_67_dropped");
    send(8'h3C); send(8'h00);
    expect_now(K_ACT, 4'b1110, "steal_60_gone");
    expect_now(K_ACT_NS, 4'b1110, "nosteal_60_kept_v0");
    send(8'hB0); send(8'h7B); send(8'h00);
    expect_now(K_ACT, 4'b0000, "all_off_ch0");
    expect_now(K_ACT_NS, 4'b0000, "all_off_ch0_ns");

    // Channel filtering and retrigger.
    omni = 1'b0;
    chan = 4'd2;
    send(8'h91); send(8'h3C); send(8'h64);
    expect_now(K_ACT, 4'b0000, "foreign_ch1");
    send(8'h3C); send(8'h64);
    expect_now(K_ACT, 4'b0000, "foreign_running");
    send(8'h92); send(8'h3C); send(8'h64);
    expect_now(K_ACT, 4'b0001, "ch2_alloc_v0");
    send(8'h3C); send(8'h64);
    expect_now(K_ACT, 4'b0001, "ch2_retrigger_no_v1");
    send(8'h3C); send(8'h00);
    expect_now(K_ACT, 4'b0000, "ch2_release");

    // Oscillator timing on note 127 (H=1993), with a retrigger resetting the phase.
    send(8'h7F); send(8'h64);
    a0 = cyc;
    expect_now(K_OSC0, 0, "osc_start_low");
    tick(500);
    send(8'h7F); send(8'h64);
    a1 = cyc;
    expect_now(K_ACT, 4'b0001, "retrig_single_voice");
    expect_at(a0 + H127, K_OSC0, 0, "retrig_old_edge_gone");
    expect_at(a1 + H127 - 1, K_OSC0, 0, "osc_before_rise");
    expect_at(a1 + H127, K_OSC0, 1, "osc_rise");
    expect_at(a1 + 2 * H127 - 1, K_OSC0, 1, "osc_before_fall");
    expect_at(a1 + 2 * H127, K_OSC0, 0, "osc_fall");
    expect_at(a1 + 3 * H127, K_OSC0, 1, "osc_second_rise");

    // Second oscillator (note 115, H=3986); mix is high 2 of every 4 cycles while both high.
    send(8'h73); send(8'h64);
    expect_now(K_ACT, 4'b0011, "alloc_v1_115");
    n = 0;
    while ($countones(osc) != 2 && n < 12000) begin
      tick();
      n++;
    end
    if ($countones(osc) != 2) begin
      checks++;
      failures++;
      $display("FAIL mix_wait: two oscillators never high together within %0d cycles", n);
    end else begin
      det = cyc;
      expect_at(det + 4, K_OSCCNT, 2, "two_osc_high");
      expect_at(det + 5, K_MIXWIN, 2, "mix_2_of_4");
    end
    drain(20000);

    // Real-time byte between D1 and D2, then All-Notes-Off on channel 2.
    send(8'h41);
    send(8'hF8);
    expect_now(K_ACT, 4'b0011, "rt_byte_no_exec");
    send(8'h64);
    expect_now(K_ACT, 4'b0111, "rt_byte_note_completes");
    send(8'hB2); send(8'h7B); send(8'h00);
    expect_now(K_ACT, 4'b0000, "cc123_release_all");
    expect_now(K_OSC, 4'b0000, "cc123_osc_low");

    // Reset mid-note and mid-message.
    send(8'h92); send(8'h7F); send(8'h64);
    tick(H127 + 5);
    expect_now(K_OSC0, 1, "pre_reset_osc_high");
    send(8'h92); send(8'h30);
    rst = 1'b1;
    tick();
    expect_now(K_ACT, 0, "midnote_reset_active");
    expect_now(K_OSC, 0, "midnote_reset_osc");
    expect_now(K_MIX, 0, "midnote_reset_mix");
    rst = 1'b0;
    send(8'h64);
    expect_now(K_ACT, 0, "partial_msg_discarded");
    expect_now(K_ACT_NS, 0, "partial_msg_discarded_ns");

    drain(100);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_voice_core.md
# poly_voice_core

Parametrised polyphonic MIDI voice engine: consumes already-deserialised MIDI bytes, parses Note On/Off and All-Notes-Off with running status, allocates notes to `VOICES` square-wave oscillators with a selectable steal policy, and emits per-voice square outputs plus a 1-bit PDM mix. It succeeds the fixed-voice synth core, adding channel filtering, voice stealing, retrigger and a mixed output. It sits between the UART receiver and the chip output pins.

## Interface
- `VOICES`, 4: oscillator count, 1..8
- `HP_W`, 22: half-period counter width
- `STEAL`, 1: 0 = ignore note-on when full, 1 = steal oldest voice
- `BASE_DIV`, 12×16-bit packed: top-octave half-periods, entry k = round(50e6 / (2·440·2^((120+k−69)/12))); k=0 → 2986
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, synchronous, active-high
- `rxByte_i` in 8: MIDI byte
- `rxValid_i` in 1: one-cycle strobe, byte valid; no backpressure, one byte accepted per cycle
- `chan_i` in 4: listened MIDI channel
- `omni_i` in 1: 1 = accept all channels
- `oscOut_o` out VOICES: per-voice square wave
- `active_o` out VOICES: voice holds a note
- `mixPwm_o` out 1: PDM of count of high oscillators

## Operation
- Parser states: NOSTAT, WAIT_D1, WAIT_D2.
  - Status byte 0x80–0xEF: latch status; channel match (`omni_i` or low nibble == `chan_i`) → WAIT_D1, else mark running status as "foreign" (data bytes consumed, no action).
  - 0xF0–0xF7: clear running status → NOSTAT. 0xF8–0xFF: ignored, state unchanged.
  - Data byte in NOSTAT: dropped. Two-data-byte messages (0x8,0x9,0xA,0xB,0xE): D1 → WAIT_D2, D2 → execute → WAIT_D1 (running status). 0xC,0xD: D1 → execute (no-op) → WAIT_D1.
- Actions (bit 7 of data masked):
  - Note On (0x9n, vel>0): note already in an active voice → retrigger that voice; else lowest-index free voice; if none free: `STEAL`=0 drop, `STEAL`=1 take voice of maximum age (lowest index on tie).
  - Note Off (0x8n, or 0x9n vel=0): release every active voice holding that note; no match → no-op.
  - CC 0xBn, controller 123: release all voices. Other CCs, 0xA, 0xE: no-op.
- Age: on allocate/steal/retrigger, that voice age=0; every other active voice age+1, saturating at VOICES−1.
- Oscillator: oct = note/12, k = note%12; half-period H = BASE_DIV[k] << (10−oct). Counter counts 0..H−1; at H−1 it wraps to 0 and the output toggles. Allocate/retrigger/steal: counter=0, output=0. Inactive voice: counter=0, output=0.
- Mix: modulo-VOICES phase counter p; `mixPwm_o` = (p < number of `oscOut_o` bits high).

## Timing
- Reset: parser NOSTAT, no running status, all voices inactive, ages 0, counters 0; `oscOut_o`=0, `active_o`=0, `mixPwm_o`=0, p=0.
- Executing byte strobed in cycle t → `active_o`/note/age updated at edge ending t; visible in t+1.
- First `oscOut_o` rise of a new note H cycles after `active_o` rises; period 2H.
- Release: `oscOut_o` and `active_o` low in t+1.
- Reset asserted mid-message or mid-note: full reset state next cycle; partial message discarded.
- Real-time byte between D1 and D2: message still completes on D2.
- `rxValid_i` low: parser holds; oscillators keep running.

## Test plan
- Reset, omni=1: bytes 0x90,0x3C,0x64 → `active_o`[0]=1 next cycle; `oscOut_o`[0] rises 95552 cycles later, period 191104.
- Running status: 0x90,0x3C,0x64,0x40,0x64,0x3C,0x00 → voice1 holds note 0x40; voice0 released; `active_o`=0b0010.
- VOICES=4, STEAL=1: five note-ons 60,62,64,65,67 → note 67 in voice0; STEAL=0 → note 67 dropped, voices 0..3 unchanged.
- chan_i=2, omni=0: 0x91,0x3C,0x64 ignored (`active_o`=0); 0x92,0x3C,0x64 allocates voice0; 0x92,0x3C,0x64 again retriggers voice0 (counter reset, no second voice).
- 0xB2,0x7B,0x00 with 3 voices active → `active_o`=0 next cycle; 0xF8 inserted between D1 and D2 of a note-on → note still allocated.
- Two oscillators high, VOICES=4 → `mixPwm_o` high 2 of every 4 cycles; reset mid-note → all outputs 0 next cycle.
